alu_1_operand_xbar: RTL

//  Operand crossbar and pairing stage directly upstream of alu_1 in each RMT action stage.

---
 rtl/alu_1_operand_xbar.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_1_operand_xbar.sv
// alu_1_operand_xbar: pairs a PHV with its sub-action (which may arrive in
// different cycles), selects two 48-bit operands from the PHV containers and
// issues the pair to alu_1 with registered outputs.
// Optional feature macro: ALU1_XBAR_IMM_EN -- when defined, opcode[3]=1 selects
// the immediate form (operand_2 = zero-extended imm11); when undefined such
// actions are issued as a NOP with zero operands.
module alu_1_operand_xbar #(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int NUM_CONT   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CONT*DATA_WIDTH-1:0]   phv_in,
  input  logic                             phv_valid_in,
  input  logic [ACTION_LEN-1:0]            action_in,
  input  logic                             action_valid_in,
  output logic [ACTION_LEN-1:0]            action_out,
  output logic                             action_valid_out,
  output logic [DATA_WIDTH-1:0]            operand_1_out,
  output logic [DATA_WIDTH-1:0]            operand_2_out,
  output logic [NUM_CONT*DATA_WIDTH-1:0]   phv_out,
  output logic                             err_overflow,
  output logic                             err_index
);

  localparam int PHV_W = NUM_CONT * DATA_WIDTH;
  localparam logic [5:0] NUM_CONT_L = 6'(NUM_CONT);

  // The action field layout is fixed, so reject configurations it cannot fit.
  if (STAGE_ID < 0 || ACTION_LEN < 25 || DATA_WIDTH < 11 || NUM_CONT < 1 || NUM_CONT > 32) begin : g_param_check
    $error("alu_1_operand_xbar: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_PHV = 2'd1,
    HOLD_ACT = 2'd2
  } state_t;

  state_t                  state_r, state_next_s;
  logic [PHV_W-1:0]        phv_hold_r;
  logic [ACTION_LEN-1:0]   act_hold_r;

  logic                    issue_s, latch_phv_s, latch_act_s, overflow_s;
  logic [PHV_W-1:0]        issue_phv_s;
  logic [ACTION_LEN-1:0]   issue_act_s;

  logic [3:0]              opc_s;
  logic [10:0]             imm_s;
  logic [4:0]              src1_s, src2_s;
  logic                    src1_ok_s, src2_ok_s;
  logic [DATA_WIDTH-1:0]   op1_s, op2_s;
  logic [ACTION_LEN-1:0]   act_fwd_s;
  logic                    idx_err_s;

  // Return container idx of the PHV, or zero when idx is out of range.
  function automatic logic [DATA_WIDTH-1:0] sel_cont(input logic [PHV_W-1:0] phv,
                                                     input logic [4:0] idx);
    sel_cont = '0;
    for (int i = 0; i < NUM_CONT; i++) begin
      if (32'(idx) == i) begin
        sel_cont = phv[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_cont = sel_cont;
      end
    end
  endfunction

  // Pairing FSM: decide issue, holding-register loads and overflow drops.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    latch_phv_s  = 1'b0;
    latch_act_s  = 1'b0;
    overflow_s   = 1'b0;
    issue_phv_s  = phv_in;
    issue_act_s  = action_in;
    case (state_r)
      IDLE: begin
        if (phv_valid_in && action_valid_in) begin
          issue_s = 1'b1;
        end else if (phv_valid_in) begin
          latch_phv_s  = 1'b1;
          state_next_s = HOLD_PHV;
        end else if (action_valid_in) begin
          latch_act_s  = 1'b1;
          state_next_s = HOLD_ACT;
        end else begin
          state_next_s = IDLE;
        end
      end
      HOLD_PHV: begin
        issue_phv_s = phv_hold_r;
        if (action_valid_in) begin
          issue_s      = 1'b1;
          overflow_s   = phv_valid_in;
          state_next_s = IDLE;
        end else if (phv_valid_in) begin
          overflow_s = 1'b1;
        end else begin
          state_next_s = HOLD_PHV;
        end
      end
      HOLD_ACT: begin
        issue_act_s = act_hold_r;
        if (phv_valid_in) begin
          issue_s      = 1'b1;
          overflow_s   = action_valid_in;
          state_next_s = IDLE;
        end else if (action_valid_in) begin
          overflow_s = 1'b1;
        end else begin
          state_next_s = HOLD_ACT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign opc_s     = issue_act_s[24:21];
  assign imm_s     = issue_act_s[20:10];
  assign src1_s    = issue_act_s[9:5];
  assign src2_s    = issue_act_s[4:0];
  assign src1_ok_s = ({1'b0, src1_s} < NUM_CONT_L);
  assign src2_ok_s = ({1'b0, src2_s} < NUM_CONT_L);

  // Operand crossbar and opcode rewrite for the pair being issued.
  always_comb begin
    op1_s     = '0;
    op2_s     = '0;
    act_fwd_s = issue_act_s;
    idx_err_s = 1'b0;
    if (opc_s[3] == 1'b0) begin
      op1_s     = sel_cont(issue_phv_s, src1_s);
      op2_s     = sel_cont(issue_phv_s, src2_s);
      idx_err_s = !src1_ok_s || !src2_ok_s;
    end else begin
`ifdef ALU1_XBAR_IMM_EN
      op1_s         = sel_cont(issue_phv_s, src1_s);
      op2_s         = {{(DATA_WIDTH-11){1'b0}}, imm_s};
      act_fwd_s[24] = 1'b0;
      idx_err_s     = !src1_ok_s;
`else
      // Immediate form unsupported in this build: issue a NOP.
      act_fwd_s = '0;
      op1_s     = '0;
      op2_s     = '0;
      idx_err_s = 1'b0;
`endif
    end
  end

  // State, holding registers, registered outputs and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      phv_hold_r       <= '0;
      act_hold_r       <= '0;
      action_out       <= '0;
      action_valid_out <= 1'b0;
      operand_1_out    <= '0;
      operand_2_out    <= '0;
      phv_out          <= '0;
      err_overflow     <= 1'b0;
      err_index        <= 1'b0;
    end else begin
      state_r          <= state_next_s;
      action_valid_out <= issue_s;
      if (latch_phv_s) phv_hold_r <= phv_in;
      if (latch_act_s) act_hold_r <= action_in;
      if (issue_s) begin
        action_out    <= act_fwd_s;
        operand_1_out <= op1_s;
        operand_2_out <= op2_s;
        phv_out       <= issue_phv_s;
      end
      if (overflow_s) err_overflow <= 1'b1;
      if (issue_s && idx_err_s) err_index <= 1'b1;
    end
  end

endmodule
